// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the single-cycle datapath.
// Holds the instruction register and steps each instruction through 3-5 states.
//
//   state  | meaning
//   FETCH  | latch instr into IR, no strobes
//   DECODE | classify IR, flag illegal encodings
//   EXEC   | branch resolves and retires here; ALU/mem ops move on
//   MEM    | store writes RAM and retires; load waits for read data
//   WB     | register-file write, retire
//   NOP    | illegal instruction retired as no-op (HALT_ON_ILLEGAL = 0)
//   TRAP   | illegal instruction, frozen until reset (HALT_ON_ILLEGAL = 1)
module multicycle_ctrl #(
    parameter bit HALT_ON_ILLEGAL = 1'b1,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic [3:0]       status,
    input  logic             stall,
    output logic             pc_en,
    output logic             pcsrc,
    output logic             alusrc,
    output logic [3:0]       aluop,
    output logic             mrw,
    output logic             wb,
    output logic             regrw,
    output logic [1:0]       immgen_ctrl,
    output logic             illegal,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_NOP, S_TRAP
    } state_t;

    state_t      state, state_nx;
    logic [31:0] ir;

    logic        dec_legal, dec_alusrc, dec_wb;
    logic        is_load, is_store, is_branch;
    logic [3:0]  dec_aluop;
    logic [1:0]  dec_imm;
    logic        taken;
    logic        dec_vis, dec_en;
    logic        pc_en_s, mrw_s, regrw_s, pcsrc_s;

    logic        is_r;
    logic [2:0]  f3;
    logic        f7b;

    assign is_r = (ir[6:0] == OP_R);
    assign f3   = ir[14:12];
    assign f7b  = ir[30];

    always_comb begin
        dec_legal  = 1'b0;
        dec_aluop  = 4'b0000;
        dec_alusrc = 1'b0;
        dec_imm    = 2'b00;
        dec_wb     = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_branch  = 1'b0;
        case (ir[6:0])
            OP_R, OP_I: begin
                dec_alusrc = !is_r;
                dec_wb     = 1'b1;
                dec_legal  = 1'b1;
                case (f3)
                    3'b000:  dec_aluop = (is_r && f7b) ? 4'b0001 : 4'b0000;
                    3'b111:  dec_aluop = 4'b0010;
                    3'b110:  dec_aluop = 4'b0011;
                    3'b100:  dec_aluop = 4'b0100;
                    3'b001: begin
                        dec_aluop = 4'b0101;
                        dec_legal = !f7b;
                    end
                    3'b101:  dec_aluop = f7b ? 4'b0111 : 4'b0110;
                    3'b010: begin
                        // SLTI has an immediate in bit 30; only SLT checks funct7
                        dec_aluop = 4'b1000;
                        dec_legal = !(is_r && f7b);
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_LD: begin
                dec_legal  = (f3 == 3'b010);
                dec_alusrc = 1'b1;
                is_load    = 1'b1;
            end
            OP_ST: begin
                dec_legal  = (f3 == 3'b010);
                dec_alusrc = 1'b1;
                dec_imm    = 2'b01;
                dec_wb     = 1'b1;
                is_store   = 1'b1;
            end
            OP_BR: begin
                dec_legal = (f3 == 3'b000) || (f3 == 3'b001) ||
                            (f3 == 3'b100) || (f3 == 3'b101);
                dec_aluop = 4'b0001;
                dec_imm   = 2'b10;
                dec_wb    = 1'b1;
                is_branch = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
        if (!dec_legal) begin
            dec_aluop  = 4'b0000;
            dec_alusrc = 1'b0;
            dec_imm    = 2'b00;
            dec_wb     = 1'b0;
            is_load    = 1'b0;
            is_store   = 1'b0;
            is_branch  = 1'b0;
        end
    end

    // status = {N, Z, C, V}
    always_comb begin
        case (f3)
            3'b000:  taken = status[2];
            3'b001:  taken = !status[2];
            3'b100:  taken = status[3] ^ status[0];
            3'b101:  taken = !(status[3] ^ status[0]);
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        dec_vis  = 1'b0;
        pc_en_s  = 1'b0;
        mrw_s    = 1'b0;
        regrw_s  = 1'b0;
        pcsrc_s  = 1'b0;
        case (state)
            S_FETCH:  state_nx = S_DECODE;
            S_DECODE: begin
                dec_vis = 1'b1;
                if (!dec_legal)
                    state_nx = HALT_ON_ILLEGAL ? S_TRAP : S_NOP;
                else
                    state_nx = S_EXEC;
            end
            S_EXEC: begin
                dec_vis = 1'b1;
                if (is_branch) begin
                    pc_en_s  = 1'b1;
                    pcsrc_s  = taken;
                    state_nx = S_FETCH;
                end else if (is_load || is_store) begin
                    state_nx = S_MEM;
                end else begin
                    state_nx = S_WB;
                end
            end
            S_MEM: begin
                dec_vis = 1'b1;
                if (is_store) begin
                    mrw_s    = 1'b1;
                    pc_en_s  = 1'b1;
                    state_nx = S_FETCH;
                end else begin
                    state_nx = S_WB;
                end
            end
            S_WB: begin
                dec_vis  = 1'b1;
                regrw_s  = 1'b1;
                pc_en_s  = 1'b1;
                state_nx = S_FETCH;
            end
            S_NOP: begin
                pc_en_s  = 1'b1;
                state_nx = S_FETCH;
            end
            S_TRAP:   state_nx = S_TRAP;
            default:  state_nx = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_FETCH;
            ir          <= '0;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
            illegal     <= 1'b0;
        end else if (!stall) begin
            state     <= state_nx;
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (state == S_FETCH)
                ir <= instr;
            if (pc_en_s)
                instret_cnt <= instret_cnt + CNT_W'(1);
            if (state == S_DECODE && !dec_legal)
                illegal <= 1'b1;
        end
    end

    // Strobes drop while stalled; the held state re-issues them afterwards
    assign dec_en      = dec_vis & ~reset;
    assign pc_en       = pc_en_s & ~stall & ~reset;
    assign mrw         = mrw_s & ~stall & ~reset;
    assign regrw       = regrw_s & ~stall & ~reset;
    assign pcsrc       = pcsrc_s & ~reset;
    assign aluop       = dec_aluop & {4{dec_en}};
    assign alusrc      = dec_alusrc & dec_en;
    assign wb          = dec_wb & dec_en;
    assign immgen_ctrl = dec_imm & {2{dec_en}};

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed and random instructions on a halting and
// a non-halting instance, compared each cycle against a latency-based model.
module tb_multicycle_ctrl;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_ILL = 5;

    typedef struct {
        logic       pc_en;
        logic       mrw;
        logic       regrw;
        logic       pcsrc;
        logic       chk_pcsrc;
        logic       alusrc;
        logic       wb;
        logic [3:0] aluop;
        logic [1:0] imm;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, stall;
    logic [31:0] instr;
    logic [3:0]  status;

    logic        h_pc_en, h_pcsrc, h_alusrc, h_mrw, h_wb, h_regrw, h_ill;
    logic [3:0]  h_aluop;
    logic [1:0]  h_imm;
    logic [31:0] h_cyc, h_ret;
    logic        n_pc_en, n_pcsrc, n_alusrc, n_mrw, n_wb, n_regrw, n_ill;
    logic [3:0]  n_aluop;
    logic [1:0]  n_imm;
    logic [31:0] n_cyc, n_ret;

    int          n_vec, n_err;
    logic [31:0] cyc_m [2];
    logic [31:0] ret_m [2];
    logic        ill_m [2];

    // legal funct tables: funct3, funct7[5] (2 = don't care), aluop
    int r_f3 [9] = '{0, 0, 7, 6, 4, 1, 5, 5, 2};
    int r_b5 [9] = '{0, 1, 2, 2, 2, 0, 0, 1, 0};
    int r_op [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
    int i_f3 [8] = '{0, 7, 6, 4, 1, 5, 5, 2};
    int i_b5 [8] = '{2, 2, 2, 2, 0, 0, 1, 2};
    int i_op [8] = '{0, 2, 3, 4, 5, 6, 7, 8};
    int b_f3 [4] = '{0, 1, 4, 5};

    always #5 clk = ~clk;

    multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b1), .CNT_W(32)) u_halt (
        .clk(clk), .reset(reset), .instr(instr), .status(status), .stall(stall),
        .pc_en(h_pc_en), .pcsrc(h_pcsrc), .alusrc(h_alusrc), .aluop(h_aluop),
        .mrw(h_mrw), .wb(h_wb), .regrw(h_regrw), .immgen_ctrl(h_imm),
        .illegal(h_ill), .cycle_cnt(h_cyc), .instret_cnt(h_ret)
    );

    multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b0), .CNT_W(32)) u_nop (
        .clk(clk), .reset(reset), .instr(instr), .status(status), .stall(stall),
        .pc_en(n_pc_en), .pcsrc(n_pcsrc), .alusrc(n_alusrc), .aluop(n_aluop),
        .mrw(n_mrw), .wb(n_wb), .regrw(n_regrw), .immgen_ctrl(n_imm),
        .illegal(n_ill), .cycle_cnt(n_cyc), .instret_cnt(n_ret)
    );

    function automatic void classify(input logic [31:0] ins, output int kind,
                                     output logic [3:0] op, output logic asrc,
                                     output logic [1:0] imm, output logic wbv);
        int f3, b5;
        f3   = int'(ins[14:12]);
        b5   = int'(ins[30]);
        kind = K_ILL; op = 4'd0; asrc = 1'b0; imm = 2'b00; wbv = 1'b0;
        if (ins[6:0] == 7'b0110011) begin
            for (int i = 0; i < 9; i++)
                if (r_f3[i] == f3 && (r_b5[i] == 2 || r_b5[i] == b5)) begin
                    kind = K_R; op = 4'(r_op[i]); wbv = 1'b1;
                end
        end else if (ins[6:0] == 7'b0010011) begin
            for (int i = 0; i < 8; i++)
                if (i_f3[i] == f3 && (i_b5[i] == 2 || i_b5[i] == b5)) begin
                    kind = K_I; op = 4'(i_op[i]); asrc = 1'b1; wbv = 1'b1;
                end
        end else if (ins[6:0] == 7'b0000011 && f3 == 2) begin
            kind = K_LD; asrc = 1'b1;
        end else if (ins[6:0] == 7'b0100011 && f3 == 2) begin
            kind = K_ST; asrc = 1'b1; imm = 2'b01; wbv = 1'b1;
        end else if (ins[6:0] == 7'b1100011 && (f3 == 0 || f3 == 1 || f3 == 4 || f3 == 5)) begin
            kind = K_BR; op = 4'd1; imm = 2'b10; wbv = 1'b1;
        end
    endfunction

    function automatic int lat_of(input int kind);
        case (kind)
            K_LD:    return 5;
            K_BR:    return 3;
            K_ILL:   return 3;
            default: return 4;
        endcase
    endfunction

    function automatic logic taken_of(input logic [2:0] f3, input logic [3:0] st);
        logic n, z, v;
        n = st[3]; z = st[2]; v = st[0];
        case (f3)
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return n != v;
            default: return n == v;
        endcase
    endfunction

    // Expected outputs in cycle k (1 = fetch) of an instruction
    function automatic exp_t expect_at(input logic [31:0] ins, input logic [3:0] st,
                                       input int k, input logic stalled, input logic halt);
        exp_t e;
        int kind;
        logic [3:0] op;
        logic a, w;
        logic [1:0] im;
        e = '{default: 1'b0};
        e.chk_pcsrc = !stalled;
        classify(ins, kind, op, a, im, w);
        if (kind == K_ILL) begin
            e.pc_en = !halt && k == 3 && !stalled;
            return e;
        end
        if (k >= 2) begin
            e.aluop = op; e.alusrc = a; e.imm = im; e.wb = w;
        end
        if (k == lat_of(kind) && !stalled) begin
            e.pc_en = 1'b1;
            e.regrw = (kind == K_R || kind == K_I || kind == K_LD);
            e.mrw   = (kind == K_ST);
            e.pcsrc = (kind == K_BR) && taken_of(ins[14:12], st);
        end
        return e;
    endfunction

    task automatic chk(input string tag, input int w, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s dut=%0d observed=%h expected=%h", tag, w, obs, exp);
        end
    endtask

    task automatic check_dut(input int w, input exp_t e);
        if (w == 0) begin
            chk("pc_en", 0, 32'(h_pc_en), 32'(e.pc_en));
            chk("mrw", 0, 32'(h_mrw), 32'(e.mrw));
            chk("regrw", 0, 32'(h_regrw), 32'(e.regrw));
            if (e.chk_pcsrc) chk("pcsrc", 0, 32'(h_pcsrc), 32'(e.pcsrc));
            chk("aluop", 0, 32'(h_aluop), 32'(e.aluop));
            chk("alusrc", 0, 32'(h_alusrc), 32'(e.alusrc));
            chk("wb", 0, 32'(h_wb), 32'(e.wb));
            chk("immgen", 0, 32'(h_imm), 32'(e.imm));
            chk("cycle_cnt", 0, h_cyc, cyc_m[0]);
            chk("instret", 0, h_ret, ret_m[0]);
            chk("illegal", 0, 32'(h_ill), 32'(ill_m[0]));
        end else begin
            chk("pc_en", 1, 32'(n_pc_en), 32'(e.pc_en));
            chk("mrw", 1, 32'(n_mrw), 32'(e.mrw));
            chk("regrw", 1, 32'(n_regrw), 32'(e.regrw));
            if (e.chk_pcsrc) chk("pcsrc", 1, 32'(n_pcsrc), 32'(e.pcsrc));
            chk("aluop", 1, 32'(n_aluop), 32'(e.aluop));
            chk("alusrc", 1, 32'(n_alusrc), 32'(e.alusrc));
            chk("wb", 1, 32'(n_wb), 32'(e.wb));
            chk("immgen", 1, 32'(n_imm), 32'(e.imm));
            chk("cycle_cnt", 1, n_cyc, cyc_m[1]);
            chk("instret", 1, n_ret, ret_m[1]);
            chk("illegal", 1, 32'(n_ill), 32'(ill_m[1]));
        end
    endtask

    // Entered just after a negedge; returns just after the next one
    task automatic cycle(input logic [31:0] d, input logic [3:0] st, input logic stl,
                         input exp_t e0, input exp_t e1, input logic en1);
        instr = d; status = st; stall = stl;
        #1;
        check_dut(0, e0);
        if (en1) check_dut(1, e1);
        @(negedge clk);
        for (int w = 0; w < 2; w++)
            if (!stl) cyc_m[w]++;
        if (e0.pc_en) ret_m[0]++;
        if (e1.pc_en) ret_m[1]++;
    endtask

    task automatic step(input logic [31:0] ins, input int k, input logic [3:0] st, input logic stl);
        int kind, lat;
        logic [3:0] op, sv;
        logic a, w;
        logic [1:0] im;
        logic [31:0] d;
        exp_t e0, e1;
        classify(ins, kind, op, a, im, w);
        lat = lat_of(kind);
        d  = (k == 1) ? ins : $urandom;
        sv = (k == lat) ? st : 4'($urandom);
        e0 = expect_at(ins, sv, k, stl, 1'b1);
        e1 = expect_at(ins, sv, k, stl, 1'b0);
        cycle(d, sv, stl, e0, e1, (kind != K_ILL) || (k <= 4));
        if (kind == K_ILL && k == 2 && !stl) begin
            ill_m[0] = 1'b1;
            ill_m[1] = 1'b1;
        end
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic [3:0] st, input int sk, input int sn);
        int kind, lat;
        logic [3:0] op;
        logic a, w;
        logic [1:0] im;
        classify(ins, kind, op, a, im, w);
        lat = lat_of(kind);
        for (int k = 1; k <= lat; k++) begin
            if (k == sk)
                for (int s = 0; s < sn; s++) step(ins, k, st, 1'b1);
            step(ins, k, st, 1'b0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b1; instr = $urandom; status = 4'($urandom);
        #1;
        chk("rst_pc_en", 0, 32'(h_pc_en), 32'd0);
        chk("rst_mrw", 0, 32'(h_mrw), 32'd0);
        chk("rst_regrw", 0, 32'(h_regrw), 32'd0);
        chk("rst_pc_en", 1, 32'(n_pc_en), 32'd0);
        chk("rst_mrw", 1, 32'(n_mrw), 32'd0);
        chk("rst_regrw", 1, 32'(n_regrw), 32'd0);
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            cyc_m[w] = 32'd0; ret_m[w] = 32'd0; ill_m[w] = 1'b0;
        end
        chk("rst_cycle_cnt", 0, h_cyc, cyc_m[0]);
        chk("rst_instret", 0, h_ret, ret_m[0]);
        chk("rst_illegal", 0, 32'(h_ill), 32'(ill_m[0]));
        chk("rst_cycle_cnt", 1, n_cyc, cyc_m[1]);
        chk("rst_instret", 1, n_ret, ret_m[1]);
        chk("rst_illegal", 1, 32'(n_ill), 32'(ill_m[1]));
        reset = 1'b0; stall = 1'b0;
    endtask

    task automatic run_ill(input logic [31:0] ins, input int n);
        for (int k = 1; k <= n; k++) step(ins, k, 4'($urandom), 1'b0);
        do_reset();
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        logic [2:0]  f3;
        logic        b5;
        logic [6:0]  up;
        int          idx;
        r = $urandom;
        case ($urandom_range(0, 4))
            0: begin
                idx = $urandom_range(0, 8);
                f3  = 3'(r_f3[idx]);
                b5  = (r_b5[idx] == 1);
                return {1'b0, b5, 5'b0, r[24:15], f3, r[11:7], 7'b0110011};
            end
            1: begin
                idx = $urandom_range(0, 7);
                f3  = 3'(i_f3[idx]);
                b5  = (i_b5[idx] == 2) ? r[30] : (i_b5[idx] == 1);
                up  = (f3 == 3'd1 || f3 == 3'd5) ? {1'b0, b5, 5'b0} : {r[31], b5, r[29:25]};
                return {up, r[24:15], f3, r[11:7], 7'b0010011};
            end
            2: return {r[31:15], 3'b010, r[11:7], 7'b0000011};
            3: return {r[31:15], 3'b010, r[11:7], 7'b0100011};
            default: begin
                f3 = 3'(b_f3[$urandom_range(0, 3)]);
                return {r[31:15], f3, r[11:7], 7'b1100011};
            end
        endcase
    endfunction

    initial begin
        logic [31:0] ins;
        int kind, lat, sk;
        logic [3:0] op;
        logic a, w;
        logic [1:0] im;
        n_vec = 0; n_err = 0;
        reset = 1'b1; stall = 1'b0; instr = 32'd0; status = 4'd0;
        do_reset();

        run_instr(32'h002081B3, 4'b0000, 0, 0);   // ADD x3,x1,x2
        run_instr(32'h00802283, 4'b0000, 0, 0);   // LW x5,8(x0)
        run_instr(32'h00502623, 4'b0000, 0, 0);   // SW x5,12(x0)
        run_instr(32'h00208463, 4'b0100, 0, 0);   // BEQ taken
        run_instr(32'h00208463, 4'b0000, 0, 0);   // BEQ not taken
        run_instr(32'h0020C463, 4'b1000, 0, 0);   // BLT taken
        run_instr(32'h0020D463, 4'b1000, 0, 0);   // BGE not taken
        run_instr(32'h00209463, 4'b0000, 0, 0);   // BNE taken
        run_instr(32'h002081B3, 4'b0000, 4, 3);   // stall 3 cycles in WB
        run_instr(32'h00802283, 4'b0000, 4, 2);   // stall in load MEM
        run_instr(32'h00502623, 4'b0000, 4, 1);   // stall over the store strobe
        run_instr(32'h0020C463, 4'b1000, 3, 2);   // stall over branch resolve

        for (int i = 0; i < 60; i++) begin
            ins = gen_instr();
            classify(ins, kind, op, a, w, im);
            lat = lat_of(kind);
            sk  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat) : 0;
            run_instr(ins, 4'($urandom), sk, $urandom_range(1, 3));
        end

        // reset lands in MEM of a store
        for (int k = 1; k <= 3; k++) step(32'h00502623, k, 4'b0000, 1'b0);
        do_reset();
        run_instr(32'h00802283, 4'b0000, 0, 0);

        run_ill(32'h0000007F, 23);
        run_ill(32'h40209033, 6);   // SLL with funct7[5] set
        run_ill(32'h00000003, 6);   // load with funct3 000
        run_instr(32'h002081B3, 4'b0000, 0, 0);
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
